mux_demux_assembler: RTL and testbench
======================================

Name: mux_demux_assembler

Overview:
- Receiving end of the 4:1 select-mux path: sequential 1:4 demultiplexer plus word assembler.
- Each accepted lane sample is steered by {sel2,sel1} into one of four lane slots of a fill buffer.
- When all four lanes are written, the assembled word moves to an output register with a valid/ready handshake.
- Sits downstream of a mux-based serializer; rebuilds the 4-lane vector the mux selected from.

Parameters:
- WIDTH, 1, bits per lane; assembled word is 4*WIDTH bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  lane sample present.
- in_ready  output  1  block can accept a sample this cycle.
- d  input  WIDTH  lane sample data.
- sel2  input  1  lane select MSB.
- sel1  input  1  lane select LSB.
- y  output  4*WIDTH  assembled word.
- out_valid  output  1  y holds a complete word.
- out_ready  input  1  consumer accepts y.
- lanes_filled  output  4  per-lane written flags of the fill buffer.

Behaviour:
- Reset: y=0, out_valid=0, lanes_filled=0, fill buffer=0, state=FILL, in_ready=1.
- Reset asserted mid-operation clears everything immediately. Any partial word or undelivered y is discarded.
- Lane map, fixed: {sel2,sel1}=00 -> lane3 = y[4W-1:3W]; 01 -> lane2; 10 -> lane1; 11 -> lane0 = y[W-1:0].
- Sample accept = in_valid & in_ready. On accept: the selected slot is written with d and its lanes_filled bit is set.
- Duplicate write to an already-filled lane in FILL: data overwritten, flag stays 1, no error.
- States:
  - FILL: in_ready=1. When an accept makes the flags 1111, the word completes on that edge.
  - On completion, if out_valid=0 or out_ready=1 that cycle: y <= completed word, out_valid <= 1, flags <= 0, stay FILL.
  - On completion otherwise: go to HOLD; buffer and flags kept at 1111.
  - HOLD: in_ready=0.
  - In HOLD, on the cycle out_ready & out_valid: y <= buffer, out_valid stays 1, flags <= 0, next FILL.
- Output handshake:
  - out_valid & out_ready with no replacement word: out_valid <= 0 next edge.
  - y remains stable while out_valid=1 and out_ready=0.
- Latency: one cycle from the edge accepting the 4th lane to out_valid high. Sustained rate is one word per 4 accepts with no bubbles while out_ready=1.
- Simultaneous events:
  - Completion and output drain in the same cycle: the new word replaces y seamlessly, out_valid stays 1.
  - Accept with in_valid high and an X-free select is always single-lane; one slot per cycle.
- in_ready is combinational from state only; there is no path from out_ready.

Optional Feature:
- Macro MUX_DEMUX_DUP_ERR_EN.
- Defined:
  - Adds output port dup_err (1 bit, reset 0).
  - A duplicate-lane write is dropped: slot data unchanged, sample still accepted (in_ready unaffected).
  - dup_err sets on the following edge and stays sticky until reset.
- Undefined: port absent; duplicate writes overwrite as above.

Test Plan:
- WIDTH=1; accept (sel=00,d=1),(01,0),(10,1),(11,1) on consecutive cycles with out_ready=1 -> one cycle after the 4th accept, y=4'b1011, out_valid=1, lanes_filled=0.
- Out-of-order fill (11,1),(00,0),(10,0),(01,1) -> y=4'b0101; lanes_filled steps through 0001,1001,1011 and then clears.
- out_ready=0, deliver two full words (1111, then 0000) -> first word held in y=1111, state HOLD, in_ready=0. Raise out_ready -> next edge y=0000, out_valid=1, in_ready=1. One more out_ready cycle -> out_valid=0.
- Duplicate write (01,1) then (01,0), then the other lanes with 1 -> y=4'b1011 (overwrite). With MUX_DEMUX_DUP_ERR_EN defined -> y=4'b1111 and dup_err=1 stays set.
- WIDTH=4: lanes 00=A,01=5,10=3,11=C -> y=16'hA53C.
- Pull rst_n low mid-word (after 2 lanes) and during HOLD -> y=0, out_valid=0, lanes_filled=0, in_ready=1 asynchronously. After release, a fresh 4-lane word assembles correctly.

Source files
------------

// File: rtl/mux_demux_assembler.sv
// 1:4 lane demultiplexer and word assembler with a valid/ready output register.
// Optional MUX_DEMUX_DUP_ERR_EN: drop duplicate-lane writes and flag them on dup_err.
module mux_demux_assembler #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   d,
    input  logic               sel2,
    input  logic               sel1,
    output logic [4*WIDTH-1:0] y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         lanes_filled
`ifdef MUX_DEMUX_DUP_ERR_EN
    ,
    output logic               dup_err
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state;
    logic [3:0][WIDTH-1:0]   fill_buf;
    logic [3:0][WIDTH-1:0]   nxt_buf;
    logic [3:0]              nxt_flags;
    logic [3:0]              lane_oh;
    logic [1:0]              lane;
    logic                    accept;
    logic                    wr_en;
    logic                    complete;
    logic                    drain;
`ifdef MUX_DEMUX_DUP_ERR_EN
    logic                    dup;
`endif

    assign in_ready = (state == FILL);

    // Select 00 addresses the top lane, 11 the bottom lane.
    always_comb begin
        lane    = 2'd3 - {sel2, sel1};
        lane_oh = 4'b0001 << lane;
        accept  = in_valid & in_ready;
`ifdef MUX_DEMUX_DUP_ERR_EN
        dup     = accept & (|(lanes_filled & lane_oh));
        wr_en   = accept & ~dup;
`else
        wr_en   = accept;
`endif
        nxt_buf = fill_buf;
        if (wr_en) begin
            nxt_buf[lane] = d;
        end
        nxt_flags = accept ? (lanes_filled | lane_oh) : lanes_filled;
        complete  = accept & (&nxt_flags);
        drain     = out_valid & out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FILL;
            fill_buf     <= '0;
            lanes_filled <= '0;
            y            <= '0;
            out_valid    <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    fill_buf <= nxt_buf;
                    if (complete) begin
                        if (!out_valid || out_ready) begin
                            y            <= nxt_buf;
                            out_valid    <= 1'b1;
                            lanes_filled <= '0;
                        end else begin
                            lanes_filled <= nxt_flags;
                            state        <= HOLD;
                        end
                    end else begin
                        lanes_filled <= nxt_flags;
                        if (drain) begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    // Parked word replaces y as the old one is taken.
                    if (drain) begin
                        y            <= fill_buf;
                        lanes_filled <= '0;
                        state        <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef MUX_DEMUX_DUP_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_err <= 1'b0;
        end else if (dup) begin
            dup_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_demux_assembler.sv
// Bench for mux_demux_assembler: WIDTH=1 and WIDTH=4 copies on shared controls,
// checked every cycle against a lane-array model plus directed literal cases.
module tb_mux_demux_assembler;

`ifdef MUX_DEMUX_DUP_ERR_EN
    localparam bit DUPEN = 1'b1;
`else
    localparam bit DUPEN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        sel2;
    logic        sel1;
    logic [3:0]  d4;
    logic        out_ready;

    logic        rdy1, rdy4;
    logic [3:0]  y1;
    logic [15:0] y4;
    logic        ov1, ov4;
    logic [3:0]  lf1, lf4;
    logic        de1, de4;

    int n_chk;
    int n_fail;
    bit run;

    mux_demux_assembler #(.WIDTH(1)) u1 (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(rdy1),
        .d(d4[0]),
        .sel2(sel2),
        .sel1(sel1),
        .y(y1),
        .out_valid(ov1),
        .out_ready(out_ready),
        .lanes_filled(lf1)
`ifdef MUX_DEMUX_DUP_ERR_EN
        ,
        .dup_err(de1)
`endif
    );

    mux_demux_assembler #(.WIDTH(4)) u4 (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(rdy4),
        .d(d4),
        .sel2(sel2),
        .sel1(sel1),
        .y(y4),
        .out_valid(ov4),
        .out_ready(out_ready),
        .lanes_filled(lf4)
`ifdef MUX_DEMUX_DUP_ERR_EN
        ,
        .dup_err(de4)
`endif
    );

`ifndef MUX_DEMUX_DUP_ERR_EN
    assign de1 = 1'b0;
    assign de4 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: four 4-bit lane slots, a flag per lane, a parked-word bit.
    logic [15:0] m_buf, m_y, nb, ny;
    logic [3:0]  m_fl, nf;
    logic        m_hold, m_ov, m_err, nh, nov, ne;

    always_comb begin
        int l;
        nb  = m_buf;
        nf  = m_fl;
        ny  = m_y;
        nov = m_ov;
        nh  = m_hold;
        ne  = m_err;
        l   = 3 - int'({sel2, sel1});
        if (m_hold) begin
            if (out_ready) begin
                ny = m_buf;
                nf = 4'b0;
                nh = 1'b0;
            end
        end else begin
            if (m_ov && out_ready) nov = 1'b0;
            if (in_valid) begin
                if (m_fl[l] && DUPEN) ne = 1'b1;
                else nb[l*4 +: 4] = d4;
                nf[l] = 1'b1;
                if (nf == 4'hf) begin
                    if (!m_ov || out_ready) begin
                        ny  = nb;
                        nov = 1'b1;
                        nf  = 4'b0;
                    end else begin
                        nh = 1'b1;
                    end
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_buf  <= '0;
            m_y    <= '0;
            m_fl   <= '0;
            m_hold <= 1'b0;
            m_ov   <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_buf  <= nb;
            m_y    <= ny;
            m_fl   <= nf;
            m_hold <= nh;
            m_ov   <= nov;
            m_err  <= ne;
        end
    end

    function automatic logic [3:0] narrow(input logic [15:0] w);
        return {w[12], w[8], w[4], w[0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("cyc y4", 32'(y4), 32'(m_y));
            chk("cyc y1", 32'(y1), 32'(narrow(m_y)));
            chk("cyc out_valid", 32'({ov1, ov4}), 32'({m_ov, m_ov}));
            chk("cyc lanes", 32'({lf1, lf4}), 32'({m_fl, m_fl}));
            chk("cyc in_ready", 32'({rdy1, rdy4}), 32'({!m_hold, !m_hold}));
            chk("cyc dup_err", 32'({de1, de4}), 32'({m_err, m_err}));
        end
    end

    task automatic step(input bit v, input logic [1:0] s,
                        input logic [3:0] dd, input bit ordy);
        in_valid  = v;
        {sel2, sel1} = s;
        d4        = dd;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " y"}, 32'({y4, y1}), 32'h0);
        chk({nm, " out_valid"}, 32'({ov1, ov4}), 32'h0);
        chk({nm, " lanes"}, 32'({lf1, lf4}), 32'h0);
        chk({nm, " in_ready"}, 32'({rdy1, rdy4}), 32'h3);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        run = 1'b0;
        in_valid = 1'b0;
        {sel2, sel1} = 2'b00;
        d4 = 4'h0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_reset("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        run = 1'b1;
        step(0, 2'd0, 4'h0, 1);

        // In-order fill, lane3..lane0 = 1,0,1,1
        step(1, 2'd0, 4'h1, 1);
        step(1, 2'd1, 4'h0, 1);
        step(1, 2'd2, 4'h1, 1);
        step(1, 2'd3, 4'h1, 1);
        chk("inorder y1", 32'(y1), 32'hb);
        chk("inorder y4", 32'(y4), 32'h1011);
        chk("inorder ov", 32'(ov1), 32'h1);
        chk("inorder lanes", 32'(lf1), 32'h0);

        // Out-of-order fill
        step(1, 2'd3, 4'h1, 1);
        chk("ooo lanes 1", 32'(lf1), 32'h1);
        step(1, 2'd0, 4'h0, 1);
        chk("ooo lanes 2", 32'(lf1), 32'h9);
        step(1, 2'd2, 4'h0, 1);
        chk("ooo lanes 3", 32'(lf1), 32'hb);
        step(1, 2'd1, 4'h1, 1);
        chk("ooo lanes 4", 32'(lf1), 32'h0);
        chk("ooo y1", 32'(y1), 32'h5);

        // Wide lanes
        step(1, 2'd0, 4'ha, 1);
        step(1, 2'd1, 4'h5, 1);
        step(1, 2'd2, 4'h3, 1);
        step(1, 2'd3, 4'hc, 1);
        chk("wide y4", 32'(y4), 32'ha53c);
        chk("wide y1", 32'(y1), 32'h6);

        // Backpressure into HOLD
        step(0, 2'd0, 4'h0, 1);
        for (int i = 0; i < 4; i++) step(1, 2'(i), 4'hf, 0);
        for (int i = 0; i < 4; i++) step(1, 2'(i), 4'h0, 0);
        chk("hold y1", 32'(y1), 32'hf);
        chk("hold y4", 32'(y4), 32'hffff);
        chk("hold in_ready", 32'(rdy1), 32'h0);
        chk("hold lanes", 32'(lf1), 32'hf);
        step(0, 2'd0, 4'h0, 1);
        chk("release y1", 32'(y1), 32'h0);
        chk("release ov", 32'(ov1), 32'h1);
        chk("release in_ready", 32'(rdy1), 32'h1);
        step(0, 2'd0, 4'h0, 1);
        chk("drain ov", 32'(ov1), 32'h0);

        // Duplicate lane write
        step(1, 2'd1, 4'h1, 1);
        step(1, 2'd1, 4'h0, 1);
        step(1, 2'd0, 4'h1, 1);
        step(1, 2'd2, 4'h1, 1);
        step(1, 2'd3, 4'h1, 1);
        chk("dup y1", 32'(y1), DUPEN ? 32'hf : 32'hb);
        chk("dup y4", 32'(y4), DUPEN ? 32'h1111 : 32'h1011);
        step(0, 2'd0, 4'h0, 1);
        chk("dup err sticky", 32'(de1), 32'(DUPEN));

        // Reset mid-word
        step(1, 2'd0, 4'h1, 1);
        step(1, 2'd1, 4'h1, 1);
        rst_n = 1'b0;
        #1;
        chk_reset("rst midword");
        rst_n = 1'b1;
        step(0, 2'd0, 4'h0, 1);

        // Reset during HOLD
        for (int i = 0; i < 8; i++) step(1, 2'(i % 4), 4'h1, 0);
        chk("pre-rst in_ready", 32'(rdy1), 32'h0);
        rst_n = 1'b0;
        #1;
        chk_reset("rst hold");
        rst_n = 1'b1;
        step(1, 2'd0, 4'h1, 1);
        step(1, 2'd1, 4'h0, 1);
        step(1, 2'd2, 4'h0, 1);
        step(1, 2'd3, 4'h1, 1);
        chk("after rst y1", 32'(y1), 32'h9);
        chk("after rst ov", 32'(ov1), 32'h1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, 2'($urandom), 4'($urandom),
                 ($urandom % 3) != 0);
        end

        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
